// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared types and constants for the fixed-point sign unit.
// Mode encoding plus MIN/MAX helpers for any lane width.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    SIGN_KEEP = 2'b00,
    SIGN_POS  = 2'b01,
    SIGN_NEG  = 2'b10,
    SIGN_FLIP = 2'b11
  } sign_mode_e;

  function automatic logic [63:0] fp_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] fp_max(input int unsigned w);
    return fp_min(w) - 64'd1;
  endfunction

endpackage

// File: rtl/fixed_point_sign_unit_if.sv
// fixed_point_sign_unit_if: input/output beat streams and counter access.
// slave is the unit side, master the producer/consumer side.
interface fixed_point_sign_unit_if #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16
);
  import fixed_point_pkg::*;

  sign_mode_e             MODE;
  logic [LANES*WIDTH-1:0] VALUE_IN;
  logic                   VALID_IN;
  logic                   READY_OUT;
  logic [LANES*WIDTH-1:0] VALUE_OUT;
  logic [LANES-1:0]       SIGN_OUT;
  logic [LANES-1:0]       OVERFLOW;
  logic                   VALID_OUT;
  logic                   READY_IN;
  logic                   CLR_COUNT;
  logic [CNT_WIDTH-1:0]   OVF_COUNT;

  modport slave (
    input  MODE, VALUE_IN, VALID_IN,
    input  READY_IN, CLR_COUNT,
    output READY_OUT, VALUE_OUT, SIGN_OUT,
    output OVERFLOW, VALID_OUT, OVF_COUNT
  );

  modport master (
    output MODE, VALUE_IN, VALID_IN,
    output READY_IN, CLR_COUNT,
    input  READY_OUT, VALUE_OUT, SIGN_OUT,
    input  OVERFLOW, VALID_OUT, OVF_COUNT
  );

endinterface

// File: rtl/fixed_point_negate_lane.sv
// fixed_point_negate_lane: one lane of conditional two's-complement negation.
// FIXED_POINT_SIGN_SATURATE_EN clamps -MIN to MAX; otherwise it wraps to MIN.
module fixed_point_negate_lane
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  sign_mode_e       mode,
  input  logic             neg_sel,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(fp_min(WIDTH));
`ifdef FIXED_POINT_SIGN_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(fp_max(WIDTH));
`endif

  logic             do_neg;
  logic [WIDTH-1:0] neg;

  always_comb begin
    do_neg = (mode == SIGN_FLIP) || neg_sel;
    neg    = ~x + WIDTH'(1);
    ovf    = do_neg && (x == MIN_V);
    y      = do_neg ? neg : x;
`ifdef FIXED_POINT_SIGN_SATURATE_EN
    if (ovf) y = MAX_V;
`endif
  end

endmodule

// File: rtl/fixed_point_sign_unit.sv
// fixed_point_sign_unit: 2-stage multi-lane sign operation with overflow stats.
// Optional FIXED_POINT_SIGN_SATURATE_EN saturates overflowing lanes to MAX.
module fixed_point_sign_unit
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic                   CLK,
  input logic                   RSTN,
  fixed_point_sign_unit_if.slave bus
);

  localparam int DW  = LANES * WIDTH;
  localparam int PW  = $clog2(LANES + 1);
  localparam int CW1 = CNT_WIDTH + 1;

  typedef struct packed {
    logic [DW-1:0]    lanes;
    sign_mode_e       mode;
    logic [LANES-1:0] neg_sel;
  } s1_t;

  logic             adv;
  logic             s1_valid;
  s1_t              s1_d;
  s1_t              s1;
  logic             s2_valid;
  logic [DW-1:0]    res_d;
  logic [LANES-1:0] ovf_d;
  logic [LANES-1:0] sign_d;
  logic [DW-1:0]    value_q;
  logic [LANES-1:0] sign_q;
  logic [LANES-1:0] ovf_q;

  logic                 xfer;
  logic [PW-1:0]        pop;
  logic [CW1-1:0]       sum;
  logic [CNT_WIDTH-1:0] cnt_sat;
  logic [CNT_WIDTH-1:0] cnt;

  assign adv = !s2_valid || bus.READY_IN;

  // Zero counts as positive, so force-negative leaves it alone
  always_comb begin
    s1_d.lanes   = bus.VALUE_IN;
    s1_d.mode    = bus.MODE;
    s1_d.neg_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      case (bus.MODE)
        SIGN_POS:
          s1_d.neg_sel[i] = bus.VALUE_IN[i*WIDTH+WIDTH-1];
        SIGN_NEG:
          s1_d.neg_sel[i] = !bus.VALUE_IN[i*WIDTH+WIDTH-1]
                            && (|bus.VALUE_IN[i*WIDTH +: WIDTH]);
        default:
          s1_d.neg_sel[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv) begin
      s1_valid <= bus.VALID_IN;
      if (bus.VALID_IN) s1 <= s1_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fixed_point_negate_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .x      (s1.lanes[i*WIDTH +: WIDTH]),
      .mode   (s1.mode),
      .neg_sel(s1.neg_sel[i]),
      .y      (res_d[i*WIDTH +: WIDTH]),
      .ovf    (ovf_d[i])
    );
    assign sign_d[i] = s1.lanes[i*WIDTH+WIDTH-1];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s2_valid <= 1'b0;
      value_q  <= '0;
      sign_q   <= '0;
      ovf_q    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        value_q <= res_d;
        sign_q  <= sign_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign xfer = s2_valid && bus.READY_IN;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(ovf_q[i]);
    sum     = {1'b0, cnt} + CW1'(pop);
    cnt_sat = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  end

  // A clear coinciding with a transfer keeps that beat's events
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (bus.CLR_COUNT) begin
      cnt <= xfer ? CNT_WIDTH'(pop) : '0;
    end else if (xfer) begin
      cnt <= cnt_sat;
    end
  end

  assign bus.READY_OUT = adv;
  assign bus.VALID_OUT = s2_valid;
  assign bus.VALUE_OUT = value_q;
  assign bus.SIGN_OUT  = sign_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.OVF_COUNT = cnt;

endmodule

// File: tb/tb_fixed_point_sign_unit.sv
// tb_fixed_point_sign_unit: directed tests for fixed_point_sign_unit.
// Expectations follow FIXED_POINT_SIGN_SATURATE_EN when it is defined.
module tb_fixed_point_sign_unit;
  import fixed_point_pkg::*;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = 16;

`ifdef FIXED_POINT_SIGN_SATURATE_EN
  localparam logic [7:0] OVF_V = 8'h7F;
`else
  localparam logic [7:0] OVF_V = 8'h80;
`endif

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fixed_point_sign_unit_if #(
    .WIDTH(W), .LANES(L), .CNT_WIDTH(CW)
  ) bus ();

  fixed_point_sign_unit #(
    .WIDTH(W), .LANES(L), .CNT_WIDTH(CW)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  task automatic drive_beat(input sign_mode_e m, input logic [31:0] v);
    @(negedge CLK);
    bus.MODE     = m;
    bus.VALUE_IN = v;
    bus.VALID_IN = 1'b1;
    @(negedge CLK);
    bus.VALID_IN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    bus.MODE      = SIGN_KEEP;
    bus.VALUE_IN  = '0;
    bus.VALID_IN  = 1'b0;
    bus.READY_IN  = 1'b0;
    bus.CLR_COUNT = 1'b0;
    RSTN = 1'b0;
    #12;
    checks++; if (bus.VALID_OUT !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.VALID_OUT); end
    checks++; if (bus.VALUE_OUT !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", bus.VALUE_OUT); end
    checks++; if (bus.SIGN_OUT !== 4'h0) begin failures++; $display("FAIL reset_sign got=%b exp=0", bus.SIGN_OUT); end
    checks++; if (bus.OVERFLOW !== 4'h0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.OVERFLOW); end
    checks++; if (bus.OVF_COUNT !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.OVF_COUNT); end
    checks++; if (bus.READY_OUT !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.READY_OUT); end
    @(negedge CLK);
    RSTN = 1'b1;
    bus.READY_IN = 1'b1;
  endtask

  task automatic test_force_pos();
    logic [31:0] exp;
    exp = {8'h00, 8'h05, 8'h05, OVF_V};
    @(negedge CLK);
    bus.MODE     = SIGN_POS;
    bus.VALUE_IN = {8'h00, 8'hFB, 8'h05, 8'h80};
    bus.VALID_IN = 1'b1;
    @(negedge CLK);
    bus.VALID_IN = 1'b0;
    checks++; if (bus.VALID_OUT !== 1'b0) begin failures++; $display("FAIL pos_latency got=%b exp=0", bus.VALID_OUT); end
    @(negedge CLK);
    checks++; if (bus.VALID_OUT !== 1'b1) begin failures++; $display("FAIL pos_valid got=%b exp=1", bus.VALID_OUT); end
    checks++; if (bus.VALUE_OUT !== exp) begin failures++; $display("FAIL pos_value got=%h exp=%h", bus.VALUE_OUT, exp); end
    checks++; if (bus.SIGN_OUT !== 4'b0101) begin failures++; $display("FAIL pos_sign got=%b exp=0101", bus.SIGN_OUT); end
    checks++; if (bus.OVERFLOW !== 4'b0001) begin failures++; $display("FAIL pos_ovf got=%b exp=0001", bus.OVERFLOW); end
  endtask

  task automatic test_keep();
    drive_beat(SIGN_KEEP, {8'h00, 8'hFB, 8'h05, 8'h80});
    checks++; if (bus.VALUE_OUT !== 32'h00FB0580) begin failures++; $display("FAIL keep_value got=%h exp=00fb0580", bus.VALUE_OUT); end
    checks++; if (bus.OVERFLOW !== 4'b0000) begin failures++; $display("FAIL keep_ovf got=%b exp=0000", bus.OVERFLOW); end
  endtask

  task automatic test_force_neg();
    drive_beat(SIGN_NEG, {8'h7F, 8'h80, 8'h00, 8'h05});
    checks++; if (bus.VALUE_OUT !== 32'h818000FB) begin failures++; $display("FAIL neg_value got=%h exp=818000fb", bus.VALUE_OUT); end
    checks++; if (bus.SIGN_OUT !== 4'b0100) begin failures++; $display("FAIL neg_sign got=%b exp=0100", bus.SIGN_OUT); end
    checks++; if (bus.OVERFLOW !== 4'b0000) begin failures++; $display("FAIL neg_ovf got=%b exp=0000", bus.OVERFLOW); end
  endtask

  task automatic test_negate();
    logic [31:0] exp;
    exp = {8'h81, OVF_V, 8'h00, 8'hFB};
    drive_beat(SIGN_FLIP, {8'h7F, 8'h80, 8'h00, 8'h05});
    checks++; if (bus.VALUE_OUT !== exp) begin failures++; $display("FAIL flip_value got=%h exp=%h", bus.VALUE_OUT, exp); end
    checks++; if (bus.OVERFLOW !== 4'b0100) begin failures++; $display("FAIL flip_ovf got=%b exp=0100", bus.OVERFLOW); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcv = 0;
    logic was_stall = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      bus.READY_IN = !(cyc >= 3 && cyc <= 5);
      bus.MODE     = SIGN_KEEP;
      bus.VALID_IN = (sent < 6);
      bus.VALUE_IN = 32'h01020304 + 32'h10101010 * 32'(sent);
      #1;
      if (bus.VALID_OUT && !bus.READY_IN) begin
        checks++; if (bus.READY_OUT !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", bus.READY_OUT); end
        if (was_stall) begin
          checks++; if (bus.VALUE_OUT !== held) begin failures++; $display("FAIL stall_stable got=%h exp=%h", bus.VALUE_OUT, held); end
        end
        held = bus.VALUE_OUT;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (bus.VALID_OUT && bus.READY_IN) begin
        exp = 32'h01020304 + 32'h10101010 * 32'(rcv);
        checks++; if (rcv >= 6 || bus.VALUE_OUT !== exp) begin failures++; $display("FAIL b2b_order beat=%0d got=%h exp=%h", rcv, bus.VALUE_OUT, exp); end
        rcv++;
      end
      if (bus.VALID_IN && bus.READY_OUT) sent++;
    end
    bus.VALID_IN = 1'b0;
    bus.READY_IN = 1'b1;
    checks++; if (rcv != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", rcv); end
  endtask

  task automatic test_counter();
    @(negedge CLK);
    bus.CLR_COUNT = 1'b1;
    @(negedge CLK);
    bus.CLR_COUNT = 1'b0;
    checks++; if (bus.OVF_COUNT !== 16'd0) begin failures++; $display("FAIL cnt_clear got=%0d exp=0", bus.OVF_COUNT); end
    bus.MODE = SIGN_FLIP;
    bus.VALUE_IN = {8'h80, 8'h80, 8'h01, 8'h01};
    bus.VALID_IN = 1'b1;
    repeat (3) @(negedge CLK);
    bus.VALID_IN = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (bus.OVF_COUNT !== 16'd6) begin failures++; $display("FAIL cnt_six got=%0d exp=6", bus.OVF_COUNT); end
    bus.VALUE_IN = {8'h00, 8'h00, 8'h00, 8'h80};
    bus.VALID_IN = 1'b1;
    @(negedge CLK);
    bus.VALID_IN = 1'b0;
    @(negedge CLK);
    bus.CLR_COUNT = 1'b1;
    @(negedge CLK);
    bus.CLR_COUNT = 1'b0;
    checks++; if (bus.OVF_COUNT !== 16'd1) begin failures++; $display("FAIL cnt_clr_xfer got=%0d exp=1", bus.OVF_COUNT); end
  endtask

  task automatic test_saturate_count();
    bus.MODE = SIGN_FLIP;
    bus.VALUE_IN = {4{8'h80}};
    bus.VALID_IN = 1'b1;
    repeat (16400) @(negedge CLK);
    bus.VALID_IN = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (bus.OVF_COUNT !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat got=%h exp=ffff", bus.OVF_COUNT); end
    drive_beat(SIGN_FLIP, {4{8'h80}});
    @(negedge CLK);
    checks++; if (bus.OVF_COUNT !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat_hold got=%h exp=ffff", bus.OVF_COUNT); end
  endtask

  task automatic test_reset_midstream();
    @(negedge CLK);
    bus.READY_IN = 1'b0;
    bus.MODE     = SIGN_KEEP;
    bus.VALUE_IN = 32'hA5A5A5A5;
    bus.VALID_IN = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (bus.VALID_OUT !== 1'b1 || bus.READY_OUT !== 1'b0) begin failures++; $display("FAIL rst_full got=%b/%b exp=1/0", bus.VALID_OUT, bus.READY_OUT); end
    #2;
    RSTN = 1'b0;
    #1;
    checks++; if (bus.VALID_OUT !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.VALID_OUT); end
    checks++; if (bus.OVF_COUNT !== 16'h0) begin failures++; $display("FAIL rst_count got=%h exp=0", bus.OVF_COUNT); end
    checks++; if (bus.READY_OUT !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.READY_OUT); end
    bus.VALID_IN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    bus.READY_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (bus.VALID_OUT !== 1'b0) begin failures++; $display("FAIL rst_stale cyc=%0d got=%b exp=0", i, bus.VALID_OUT); end
    end
    checks++; if (bus.READY_OUT !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", bus.READY_OUT); end
  endtask

  initial begin
    test_reset();
    test_force_pos();
    test_keep();
    test_force_neg();
    test_negate();
    test_back_to_back();
    test_counter();
    test_saturate_count();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
